// File: rtl/stage_mem_waitstate.sv
// stage_mem_waitstate: pipelined ARM MEM stage whose data memory needs a
// configurable number of wait states. It drops ready while an access is in
// flight, owns the MEM/WB register and bubbles write-back on stalled cycles.
// Optional feature macro: MEM_BYTE_ACCESS_EN adds the byte_access port and
// byte-sized loads/stores (little-endian lanes selected by alu_res[1:0]).
module stage_mem_waitstate #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2,
  parameter int BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic              mem_read_en,
  input  logic              mem_write_en,
  input  logic [ADDR_W-1:0] alu_res,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [3:0]        dest,
`ifdef MEM_BYTE_ACCESS_EN
  input  logic              byte_access,
`endif
  output logic              ready,
  output logic              wb_en_out,
  output logic              mem_read_out,
  output logic [ADDR_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        dest_out
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [3:0]        WS      = 4'(WAIT_STATES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              req;
  logic              complete;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] idx_full;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] mem [DEPTH];
`ifdef MEM_BYTE_ACCESS_EN
  logic [4:0]        lane_off;
  logic [7:0]        sel_byte;
`endif

  assign req      = mem_read_en | mem_write_en;
  assign complete = req & ready;

  // Address decode; the subtraction wraps, so the >= BASE test rejects addresses below the window
  always_comb begin
    off      = alu_res - BASE;
    idx_full = off >> 2;
    in_range = (alu_res >= BASE) && (idx_full < DEPTH_A);
    idx      = idx_full[IDX_W-1:0];
    rd_word  = in_range ? mem[idx] : '0;
  end

  // Load-data shaping and store-data merge (byte lanes only when the feature is built in)
  always_comb begin
`ifdef MEM_BYTE_ACCESS_EN
    lane_off  = {alu_res[1:0], 3'b000};
    sel_byte  = rd_word[lane_off +: 8];
    load_word = '0;
    wr_word   = val_rm;
    if (byte_access) begin
      load_word[7:0]          = sel_byte;
      wr_word                 = rd_word;
      wr_word[lane_off +: 8]  = val_rm[7:0];
    end else begin
      load_word = rd_word;
    end
`else
    load_word = rd_word;
    wr_word   = val_rm;
`endif
  end

  // State register: FSM state and wait-state counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: a request with wait states parks in BUSY until cnt reaches WAIT_STATES
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req && (WS != 4'd0)) begin
          state_nxt = BUSY;
          cnt_nxt   = 4'd1;
        end
      end
      BUSY: begin
        if (cnt == WS) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: ready is low on every cycle of an access except its completion cycle
  always_comb begin
    ready = 1'b1;
    case (state)
      IDLE:    ready = !(req && (WS != 4'd0));
      BUSY:    ready = (cnt == WS);
      default: ready = 1'b1;
    endcase
  end

  // Data array: cleared on reset, written only on the completion edge of an in-range store
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (complete && mem_write_en && in_range) begin
      mem[idx] <= wr_word;
    end
  end

  // MEM/WB register: bubble write-back while stalled, otherwise capture the instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_out    <= 1'b0;
      mem_read_out <= 1'b0;
      alu_res_out  <= '0;
      data_out     <= '0;
      dest_out     <= '0;
    end else if (!ready) begin
      wb_en_out    <= 1'b0;
      mem_read_out <= 1'b0;
    end else begin
      wb_en_out    <= wb_en;
      mem_read_out <= mem_read_en;
      alu_res_out  <= alu_res;
      data_out     <= load_word;
      dest_out     <= dest;
    end
  end

endmodule

// File: tb/tb_stage_mem_waitstate.sv
// tb_stage_mem_waitstate: scoreboard bench for stage_mem_waitstate.
// dut_a uses WAIT_STATES=2, dut_z uses WAIT_STATES=0; both share the inputs.
// Byte-lane scenarios are compiled in only with MEM_BYTE_ACCESS_EN.
module tb_stage_mem_waitstate;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en = 1'b0;
  logic        mem_read_en = 1'b0;
  logic        mem_write_en = 1'b0;
  logic [31:0] alu_res = '0;
  logic [31:0] val_rm = '0;
  logic [3:0]  dest = '0;
  logic        byte_access = 1'b0;

  logic        ready_a, wb_en_out_a, mem_read_out_a;
  logic [31:0] alu_res_out_a, data_out_a;
  logic [3:0]  dest_out_a;
  logic        ready_z, wb_en_out_z, mem_read_out_z;
  logic [31:0] alu_res_out_z, data_out_z;
  logic [3:0]  dest_out_z;

  typedef struct {
    logic        wb;
    logic        rd;
    logic [31:0] alu;
    logic [3:0]  dst;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [64];
  int          check_count = 0;
  int          pass_count = 0;

  stage_mem_waitstate #(.WAIT_STATES(2)) dut_a (
    .clk(clk), .rst(rst), .wb_en(wb_en), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .alu_res(alu_res), .val_rm(val_rm), .dest(dest),
`ifdef MEM_BYTE_ACCESS_EN
    .byte_access(byte_access),
`endif
    .ready(ready_a), .wb_en_out(wb_en_out_a), .mem_read_out(mem_read_out_a),
    .alu_res_out(alu_res_out_a), .data_out(data_out_a), .dest_out(dest_out_a)
  );

  stage_mem_waitstate #(.WAIT_STATES(0)) dut_z (
    .clk(clk), .rst(rst), .wb_en(wb_en), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .alu_res(alu_res), .val_rm(val_rm), .dest(dest),
`ifdef MEM_BYTE_ACCESS_EN
    .byte_access(byte_access),
`endif
    .ready(ready_z), .wb_en_out(wb_en_out_z), .mem_read_out(mem_read_out_z),
    .alu_res_out(alu_res_out_z), .data_out(data_out_z), .dest_out(dest_out_z)
  );

  always #5 clk = ~clk;

  // Hard stop in case something wedges the stimulus thread
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic bit inRange(input logic [31:0] addr);
    return (addr >= 32'd1024) && (((addr - 32'd1024) >> 2) < 32'd64);
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] addr);
    if (inRange(addr)) return model_mem[(addr - 32'd1024) >> 2];
    return 32'd0;
  endfunction

  function automatic logic [31:0] byteOf(input logic [31:0] word, input logic [1:0] lane);
    logic [31:0] w;
    w = word >> (8 * lane);
    return w & 32'h0000_00FF;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
  endtask

  // Drive one instruction, push its expected MEM/WB contents, then follow it to completion
  task automatic applyStimulus(input bit sel_z, input logic we, input logic rd, input logic wb,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] d, input logic bsz);
    exp_t        e, got;
    logic [31:0] old;
    int          stalls;
    int          exp_stalls;
    bit          done;
    logic        rdy;
    @(negedge clk);
    mem_write_en = we;
    mem_read_en  = rd;
    wb_en        = wb;
    alu_res      = addr;
    val_rm       = wdata;
    dest         = d;
    byte_access  = bsz;
    old          = modelRead(addr);
    e.wb         = wb;
    e.rd         = rd;
    e.alu        = addr;
    e.dst        = d;
    e.data       = bsz ? byteOf(old, addr[1:0]) : old;
    e.chk_data   = rd;
    sb_q.push_back(e);
    exp_stalls   = ((we | rd) && !sel_z) ? 2 : 0;
    stalls       = 0;
    done         = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      rdy = sel_z ? ready_z : ready_a;
      if (rdy) begin
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checkOutput("wb_en_out",    sel_z ? wb_en_out_z    : wb_en_out_a,    got.wb);
        checkOutput("mem_read_out", sel_z ? mem_read_out_z : mem_read_out_a, got.rd);
        checkOutput("alu_res_out",  sel_z ? alu_res_out_z  : alu_res_out_a,  got.alu);
        checkOutput("dest_out",     sel_z ? dest_out_z     : dest_out_a,     got.dst);
        if (got.chk_data)
          checkOutput("data_out", sel_z ? data_out_z : data_out_a, got.data);
        if (we && inRange(addr)) begin
          if (bsz) model_mem[(addr - 32'd1024) >> 2][8*addr[1:0] +: 8] = wdata[7:0];
          else     model_mem[(addr - 32'd1024) >> 2] = wdata;
        end
        done = 1'b1;
      end else begin
        stalls++;
        @(posedge clk);
        #1;
        checkOutput("bubble_wb_en", sel_z ? wb_en_out_z : wb_en_out_a, 1'b0);
        checkOutput("bubble_mem_rd", sel_z ? mem_read_out_z : mem_read_out_a, 1'b0);
        @(negedge clk);
      end
    end
    if (!done) begin
      checkOutput("ready_timeout", 32'd1, 32'd0);
      void'(sb_q.pop_front());
    end
    checkOutput("stall_cycles", stalls, exp_stalls);
  endtask

  initial begin
    clearModel();

    // Reset state
    #12;
    checkOutput("rst_ready", ready_a, 1'b1);
    checkOutput("rst_wb_en_out", wb_en_out_a, 1'b0);
    checkOutput("rst_mem_read_out", mem_read_out_a, 1'b0);
    checkOutput("rst_alu_res_out", alu_res_out_a, 32'd0);
    checkOutput("rst_data_out", data_out_a, 32'd0);
    checkOutput("rst_dest_out", dest_out_a, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    // Store then load through the wait-state memory
    applyStimulus(0, 1, 0, 0, 32'd1028, 32'hDEAD_BEEF, 4'd1, 0);
    applyStimulus(0, 0, 1, 1, 32'd1028, 32'h0,         4'd5, 0);

    // Non-memory pass-through
    applyStimulus(0, 0, 0, 1, 32'h55,   32'h0,         4'd3, 0);

    // Out-of-range stores are dropped, loads there return zero, aliasing words stay clean
    applyStimulus(0, 1, 0, 0, 32'd1000, 32'h1234,      4'd0, 0);
    applyStimulus(0, 1, 0, 0, 32'd1280, 32'h1234,      4'd0, 0);
    applyStimulus(0, 0, 1, 1, 32'd1000, 32'h0,         4'd6, 0);
    applyStimulus(0, 0, 1, 1, 32'd1280, 32'h0,         4'd7, 0);
    applyStimulus(0, 0, 1, 1, 32'd1024, 32'h0,         4'd8, 0);
    applyStimulus(0, 0, 1, 1, 32'd1256, 32'h0,         4'd9, 0);

    // Simultaneous load+store returns the old word and performs the store
    applyStimulus(0, 1, 1, 1, 32'd1028, 32'h0000_0077, 4'd10, 0);
    applyStimulus(0, 0, 1, 1, 32'd1028, 32'h0,         4'd11, 0);

    // Reset in the middle of a store
    @(negedge clk);
    mem_write_en = 1'b1;
    mem_read_en  = 1'b0;
    wb_en        = 1'b0;
    alu_res      = 32'd1032;
    val_rm       = 32'hCAFE_F00D;
    dest         = 4'd2;
    #1;
    checkOutput("rst_test_ready_first", ready_a, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rst_test_ready_busy", ready_a, 1'b0);
    @(negedge clk);
    rst          = 1'b1;
    mem_write_en = 1'b0;
    #1;
    checkOutput("midrst_ready", ready_a, 1'b1);
    checkOutput("midrst_wb_en_out", wb_en_out_a, 1'b0);
    checkOutput("midrst_mem_read_out", mem_read_out_a, 1'b0);
    checkOutput("midrst_alu_res_out", alu_res_out_a, 32'd0);
    checkOutput("midrst_data_out", data_out_a, 32'd0);
    checkOutput("midrst_dest_out", dest_out_a, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    clearModel();
    applyStimulus(0, 0, 1, 1, 32'd1032, 32'h0,         4'd12, 0);

`ifdef MEM_BYTE_ACCESS_EN
    // Byte lanes: merge a byte into a word, then read word and a single byte
    applyStimulus(0, 1, 0, 0, 32'd1024, 32'h1122_3344, 4'd0, 0);
    applyStimulus(0, 1, 0, 0, 32'd1025, 32'h0000_00AA, 4'd0, 1);
    applyStimulus(0, 0, 1, 1, 32'd1024, 32'h0,         4'd4, 0);
    applyStimulus(0, 0, 1, 1, 32'd1027, 32'h0,         4'd4, 1);
    checkOutput("byte_model_word", modelRead(32'd1024), 32'h1122_AA44);
`endif

    // Zero wait states: back-to-back store and load with no stall
    applyStimulus(1, 1, 0, 0, 32'd1040, 32'h600D_F00D, 4'd1, 0);
    applyStimulus(1, 0, 1, 1, 32'd1040, 32'h0,         4'd13, 0);
    applyStimulus(1, 0, 0, 0, 32'h0,    32'h0,         4'd0, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
